wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback-select stage of the RISC-V core; sits directly upstream of the register file.
- Drives the register file's write port (RegWrite, wr, wd).
- Performs load-data byte/halfword extraction and sign/zero extension, and suppresses writes to x0.
- Detects misaligned/illegal loads.
- Exposes the registered result for forwarding and counts retired instructions.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream slot holds a real instruction.
- in_ready  out  1  stage accepts this cycle; equals !stall (combinational).
- stall  in  1  hazard unit freeze; stage holds all state.
- flush  in  1  squash incoming slot; insert bubble.
- in_reg_write  in  1  instruction writes rd.
- in_rd  in  5  destination register.
- in_wb_sel  in  2  00 ALU, 01 load data, 10 PC+4, 11 immediate (LUI).
- in_funct3  in  3  load type when in_wb_sel==01.
- in_addr_lo  in  2  load address bits [1:0].
- in_alu_result  in  XLEN  ALU result.
- in_mem_rdata  in  XLEN  aligned 32-bit word from data memory.
- in_pc_plus4  in  XLEN  link value.
- in_imm  in  XLEN  U-type immediate.
- RegWrite  out  1  register-file write enable.
- wr  out  5  register-file write address.
- wd  out  XLEN  register-file write data.
- wb_valid  out  1  stage holds a real instruction.
- load_err  out  1  registered flag: current instruction was a misaligned or illegal load.
- retired_count  out  CNT_W  number of instructions captured with wb_valid.

Behaviour:
- Reset (async, any time, including mid-stall): RegWrite=0, wr=0, wd=0, wb_valid=0, load_err=0, retired_count=0. The first capture occurs at the first posedge after rst deasserts.

Capture priority at each posedge:
- flush=1: bubble. wb_valid=0, RegWrite=0, load_err=0; wr and wd hold. Flush overrides stall.
- Otherwise stall=1: every register holds. RegWrite stays at its value, so the register file rewrites the same value. This is idempotent and permitted.
- Otherwise: capture the slot. The sections below define wb_valid, RegWrite, wr, wd and load_err.

Captured values:
- wb_valid = in_valid.
- wr = in_rd.
- wd = the selected value, computed combinationally before the register. Latency from acceptance to RegWrite high is exactly 1 cycle. The register file commits on the following posedge.
- RegWrite = in_valid & in_reg_write & (in_rd!=0) & !err, where err is defined below.

Load extraction (in_wb_sel==01; byte b = in_addr_lo):
- 000 LB: sign-extend byte b.
- 100 LBU: zero-extend byte b.
- 001 LH: sign-extend halfword addr_lo[1]. err if addr_lo[0]=1.
- 101 LHU: as LH, but zero-extend.
- 010 LW: whole word. err if addr_lo!=0.
- 011, 110, 111: err (illegal).

Load errors:
- load_err = in_valid & (in_wb_sel==01) & err.
- On error, wd is still captured (extraction result, or the raw word for illegal funct3) but RegWrite=0.

Retired counter:
- retired_count increments by 1 on each capture with in_valid=1, including rd=x0 and errored loads.
- It is not incremented on flush, stall or bubble.
- It wraps from all-ones to 0.

Edge cases:
- in_wb_sel is ignored for stores/branches because in_reg_write=0; wd is still captured.
- Back-to-back captures are allowed every cycle with no bubbles required.

Test Plan:
- Reset mid-stream: assert rst while RegWrite=1, wd=0xDEADBEEF -> all outputs 0 immediately, retired_count=0.
- LB vs LBU: in_mem_rdata=0x80FF7F01, addr_lo=3 -> LB gives wd=0xFFFFFF80, LBU gives wd=0x00000080, RegWrite=1 one cycle after acceptance.
- Misaligned LH: funct3=001, addr_lo=1, rd=7 -> load_err=1, RegWrite=0, retired_count+1. Repeat with addr_lo=2, rdata=0xABCD1234 -> wd=0xFFFFABCD, RegWrite=1.
- x0 suppression: ALU op with rd=0, alu_result=5 -> wb_valid=1, RegWrite=0, counter+1.
- Stall then flush: capture JAL (wb_sel=10, pc_plus4=0x104, rd=1). Hold stall 3 cycles -> RegWrite=1, wd=0x104 held, counter +1 only. Then assert stall and flush together -> bubble, RegWrite=0.
- Counter wrap with CNT_W=4: 16 valid captures -> retired_count returns to 0.

Source files
------------

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback select.
// Extracts and extends load data, selects the writeback source, blocks
// writes to x0 and to faulting loads, flags misaligned/illegal loads and
// counts retired instructions. Register-file commit happens one cycle
// after the slot is accepted here.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_reg_write,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_mem_rdata,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [XLEN-1:0]  in_imm,
  output logic             RegWrite,
  output logic [4:0]       wr,
  output logic [XLEN-1:0]  wd,
  output logic             wb_valid,
  output logic             load_err,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic            ld_err;
  logic            is_load;
  logic            slot_err;
  logic [XLEN-1:0] sel_data;
  logic            next_reg_write;

  // The stage accepts whenever the hazard unit is not freezing it.
  assign in_ready = !stall;

  // Pick the addressed byte and halfword out of the aligned memory word.
  always_comb begin
    ld_byte = in_mem_rdata[7:0];
    case (in_addr_lo)
      2'd0: ld_byte = in_mem_rdata[7:0];
      2'd1: ld_byte = in_mem_rdata[15:8];
      2'd2: ld_byte = in_mem_rdata[23:16];
      2'd3: ld_byte = in_mem_rdata[31:24];
      default: ld_byte = in_mem_rdata[7:0];
    endcase
    ld_half = in_addr_lo[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
  end

  // Extend by load type; misaligned halfword/word and unknown funct3 fault.
  // Faulting loads still produce a value (extraction or raw word) so wd is
  // deterministic even though the write is suppressed.
  always_comb begin
    ld_data = in_mem_rdata;
    ld_err  = 1'b0;
    case (in_funct3)
      F3_LB:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH: begin
        ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_err  = in_addr_lo[0];
      end
      F3_LHU: begin
        ld_data = {{(XLEN-16){1'b0}}, ld_half};
        ld_err  = in_addr_lo[0];
      end
      F3_LW: begin
        ld_data = in_mem_rdata;
        ld_err  = (in_addr_lo != 2'd0);
      end
      default: begin
        ld_data = in_mem_rdata;
        ld_err  = 1'b1;
      end
    endcase
  end

  // Writeback source select and the qualified write enable.
  always_comb begin
    sel_data = in_alu_result;
    case (in_wb_sel)
      SEL_ALU:  sel_data = in_alu_result;
      SEL_LOAD: sel_data = ld_data;
      SEL_LINK: sel_data = in_pc_plus4;
      SEL_IMM:  sel_data = in_imm;
      default:  sel_data = in_alu_result;
    endcase
    is_load        = (in_wb_sel == SEL_LOAD);
    slot_err       = is_load && ld_err;
    next_reg_write = in_valid && in_reg_write && (in_rd != 5'd0) && !slot_err;
  end

  // Pipeline register: flush bubbles (keeping wr/wd), stall holds, else capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite      <= 1'b0;
      wr            <= '0;
      wd            <= '0;
      wb_valid      <= 1'b0;
      load_err      <= 1'b0;
      retired_count <= '0;
    end else if (flush) begin
      RegWrite <= 1'b0;
      wb_valid <= 1'b0;
      load_err <= 1'b0;
    end else if (!stall) begin
      RegWrite <= next_reg_write;
      wr       <= in_rd;
      wd       <= sel_data;
      wb_valid <= in_valid;
      load_err <= in_valid && slot_err;
      if (in_valid)
        retired_count <= retired_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table for single-cycle captures
// plus hand sequences for reset, stall/flush and counter wrap.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel, in_addr_lo;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4, in_imm;
  logic        in_ready, RegWrite, wb_valid, load_err;
  logic [4:0]  wr;
  logic [31:0] wd, retired_count;
  logic        in_ready4, RegWrite4, wb_valid4, load_err4;
  logic [4:0]  wr4;
  logic [31:0] wd4;
  logic [3:0]  retired_count4;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc_plus4(in_pc_plus4), .in_imm(in_imm), .RegWrite(RegWrite),
    .wr(wr), .wd(wd), .wb_valid(wb_valid), .load_err(load_err),
    .retired_count(retired_count)
  );

  wb_stage #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .stall(stall), .flush(flush), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc_plus4(in_pc_plus4), .in_imm(in_imm), .RegWrite(RegWrite4),
    .wr(wr4), .wd(wd4), .wb_valid(wb_valid4), .load_err(load_err4),
    .retired_count(retired_count4)
  );

  typedef struct {
    string       name;
    logic        valid, rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] alu, rdata, pc4, imm;
    logic        e_rw, e_vld, e_err;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic valid, logic rw, logic [4:0] rd,
                              logic [1:0] sel, logic [2:0] f3, logic [1:0] lo,
                              logic [31:0] alu, logic [31:0] rdata,
                              logic [31:0] pc4, logic [31:0] imm,
                              logic e_rw, logic e_vld, logic e_err,
                              logic [31:0] e_wd);
    vec_t v;
    v.name = name; v.valid = valid; v.rw = rw; v.rd = rd; v.sel = sel;
    v.f3 = f3; v.lo = lo; v.alu = alu; v.rdata = rdata; v.pc4 = pc4;
    v.imm = imm; v.e_rw = e_rw; v.e_vld = e_vld; v.e_err = e_err;
    v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic valid, logic rw, logic [4:0] rd, logic [1:0] sel,
                       logic [2:0] f3, logic [1:0] lo, logic [31:0] alu,
                       logic [31:0] rdata, logic [31:0] pc4, logic [31:0] imm);
    in_valid = valid; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
    in_funct3 = f3; in_addr_lo = lo; in_alu_result = alu;
    in_mem_rdata = rdata; in_pc_plus4 = pc4; in_imm = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".RegWrite"}, 32'(RegWrite), 32'd0);
    chk({tag, ".wr"}, 32'(wr), 32'd0);
    chk({tag, ".wd"}, wd, 32'd0);
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, ".load_err"}, 32'(load_err), 32'd0);
    chk({tag, ".count"}, retired_count, 32'd0);
  endtask

  initial begin
    // name valid rw rd sel f3 lo alu rdata pc4 imm | e_rw e_vld e_err e_wd
    vecs.push_back(mk("alu",      1,1,3,2'b00,3'b000,0,32'h12345678,32'h0,32'h0,32'h0, 1,1,0,32'h12345678));
    vecs.push_back(mk("lb_b3",    1,1,4,2'b01,3'b000,3,32'h0,32'h80FF7F01,32'h0,32'h0, 1,1,0,32'hFFFFFF80));
    vecs.push_back(mk("lbu_b3",   1,1,4,2'b01,3'b100,3,32'h0,32'h80FF7F01,32'h0,32'h0, 1,1,0,32'h00000080));
    vecs.push_back(mk("lb_b1",    1,1,6,2'b01,3'b000,1,32'h0,32'h80FF7F01,32'h0,32'h0, 1,1,0,32'h0000007F));
    vecs.push_back(mk("lbu_b0",   1,1,6,2'b01,3'b100,0,32'h0,32'h80FF7F01,32'h0,32'h0, 1,1,0,32'h00000001));
    vecs.push_back(mk("lh_mis",   1,1,7,2'b01,3'b001,1,32'h0,32'h80FF7F01,32'h0,32'h0, 0,1,1,32'h00007F01));
    vecs.push_back(mk("lh_hi",    1,1,7,2'b01,3'b001,2,32'h0,32'hABCD1234,32'h0,32'h0, 1,1,0,32'hFFFFABCD));
    vecs.push_back(mk("lhu_hi",   1,1,8,2'b01,3'b101,2,32'h0,32'hABCD1234,32'h0,32'h0, 1,1,0,32'h0000ABCD));
    vecs.push_back(mk("lhu_mis",  1,1,8,2'b01,3'b101,3,32'h0,32'hABCD1234,32'h0,32'h0, 0,1,1,32'h0000ABCD));
    vecs.push_back(mk("lw",       1,1,9,2'b01,3'b010,0,32'h0,32'hCAFEF00D,32'h0,32'h0, 1,1,0,32'hCAFEF00D));
    vecs.push_back(mk("lw_mis",   1,1,9,2'b01,3'b010,2,32'h0,32'hCAFEF00D,32'h0,32'h0, 0,1,1,32'hCAFEF00D));
    vecs.push_back(mk("ld_ill",   1,1,10,2'b01,3'b011,0,32'h0,32'h13572468,32'h0,32'h0, 0,1,1,32'h13572468));
    vecs.push_back(mk("ld_ill7",  1,1,10,2'b01,3'b111,0,32'h0,32'h0BADF00D,32'h0,32'h0, 0,1,1,32'h0BADF00D));
    vecs.push_back(mk("x0",       1,1,0,2'b00,3'b000,0,32'h5,32'h0,32'h0,32'h0, 0,1,0,32'h00000005));
    vecs.push_back(mk("lui",      1,1,5,2'b11,3'b000,0,32'h1,32'h2,32'h3,32'hABCDE000, 1,1,0,32'hABCDE000));
    vecs.push_back(mk("jal",      1,1,1,2'b10,3'b000,0,32'h1,32'h2,32'h200,32'h3, 1,1,0,32'h00000200));
    vecs.push_back(mk("invalid",  0,1,4,2'b01,3'b111,0,32'h99,32'h55AA55AA,32'h0,32'h0, 0,0,0,32'h55AA55AA));
    vecs.push_back(mk("store",    1,0,12,2'b00,3'b010,0,32'h400,32'h0,32'h0,32'h0, 0,1,0,32'h00000400));
    vecs.push_back(mk("ld_err_nowr", 1,0,12,2'b01,3'b010,1,32'h0,32'h11223344,32'h0,32'h0, 0,1,1,32'h11223344));

    // Reset state
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(0,0,0,0,0,0,0,0,0,0);
    #2;
    chk_zero("reset");
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;

    // Table-driven captures
    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].rw, vecs[i].rd, vecs[i].sel, vecs[i].f3,
            vecs[i].lo, vecs[i].alu, vecs[i].rdata, vecs[i].pc4, vecs[i].imm);
      tick();
      if (vecs[i].valid) exp_cnt++;
      chk({vecs[i].name, ".RegWrite"}, 32'(RegWrite), 32'(vecs[i].e_rw));
      chk({vecs[i].name, ".wr"}, 32'(wr), 32'(vecs[i].rd));
      chk({vecs[i].name, ".wd"}, wd, vecs[i].e_wd);
      chk({vecs[i].name, ".wb_valid"}, 32'(wb_valid), 32'(vecs[i].e_vld));
      chk({vecs[i].name, ".load_err"}, 32'(load_err), 32'(vecs[i].e_err));
      chk({vecs[i].name, ".count"}, retired_count, 32'(exp_cnt));
    end

    // Stall then flush: JAL captured, held through 3 stalled cycles
    drive(1,1,1,2'b10,0,0,32'h0,32'h0,32'h104,32'h0);
    tick();
    exp_cnt++;
    chk("jal.RegWrite", 32'(RegWrite), 32'd1);
    chk("jal.wd", wd, 32'h104);
    stall = 1'b1;
    #1;
    chk("stall.in_ready", 32'(in_ready), 32'd0);
    drive(1,1,9,2'b00,0,0,32'h77,32'h0,32'h0,32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall.RegWrite", 32'(RegWrite), 32'd1);
      chk("stall.wr", 32'(wr), 32'd1);
      chk("stall.wd", wd, 32'h104);
      chk("stall.wb_valid", 32'(wb_valid), 32'd1);
      chk("stall.count", retired_count, 32'(exp_cnt));
    end
    flush = 1'b1;
    tick();
    chk("flush.RegWrite", 32'(RegWrite), 32'd0);
    chk("flush.wb_valid", 32'(wb_valid), 32'd0);
    chk("flush.wr", 32'(wr), 32'd1);
    chk("flush.wd", wd, 32'h104);
    chk("flush.count", retired_count, 32'(exp_cnt));
    stall = 1'b0;
    // Flush also clears a pending load_err
    flush = 1'b0;
    drive(1,1,7,2'b01,3'b001,1,0,32'h0,0,0);
    tick();
    exp_cnt++;
    chk("err_pre.load_err", 32'(load_err), 32'd1);
    flush = 1'b1;
    tick();
    chk("err_flush.load_err", 32'(load_err), 32'd0);
    chk("err_flush.count", retired_count, 32'(exp_cnt));
    flush = 1'b0;

    // Reset mid-stream while a write is presented and the stage stalls
    drive(1,1,3,2'b00,0,0,32'hDEADBEEF,0,0,0);
    tick();
    chk("pre_rst.wd", wd, 32'hDEADBEEF);
    chk("pre_rst.RegWrite", 32'(RegWrite), 32'd1);
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    tick();
    chk_zero("rst_held");
    rst = 1'b0;
    stall = 1'b0;
    exp_cnt = 0;

    // First capture after reset release
    drive(1,1,2,2'b00,0,0,32'h0000CAFE,0,0,0);
    tick();
    chk("post_rst.wd", wd, 32'h0000CAFE);
    chk("post_rst.count", retired_count, 32'd1);

    // Counter wrap on the 4-bit instance
    #1;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(1,1,3,2'b00,0,0,32'h1,0,0,0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 15) chk("wrap.ones", 32'(retired_count4), 32'd15);
    end
    chk("wrap.zero", 32'(retired_count4), 32'd0);
    chk("wrap.wide", retired_count, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
